// File: rtl/pq_register_file.sv
// Unified PQ/GP register file with core ports and a streaming load/unload engine.
// Optional core read forwarding is enabled by defining PQ_RF_BYPASS_EN.
module pq_register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wdata_pq_i    [0:31],
    input  logic [31:0]           we_pq_i,
    input  logic [DATA_WIDTH-1:0] wdata_pq_gp_i [0:17],
    input  logic [17:0]           we_pq_gp_i,
    output logic [DATA_WIDTH-1:0] rdata_pq_o    [0:31],
    output logic [DATA_WIDTH-1:0] rdata_pq_gp_o [0:17],
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    output logic [DATA_WIDTH-1:0] rdata_a_o,
    output logic [DATA_WIDTH-1:0] rdata_b_o,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  we_i,
    input  logic                  start_load_i,
    input  logic                  start_unload_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [5:0]            count_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    output logic                  s_ready_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i
);

    localparam int unsigned NUM_PQ   = 32;
    localparam int unsigned NUM_GP   = 18;
    localparam int unsigned NUM_REGS = NUM_PQ + NUM_GP;
    localparam logic [ADDR_WIDTH-1:0] LAST_MAPPED = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(63);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_ptr_inc;
    logic [5:0]            r_rem;
    logic [5:0]            w_rem_nxt;
    logic                  w_load_we;

    logic [DATA_WIDTH-1:0] r_regs      [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_regs_nxt  [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_core_src  [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] w_unload_word;

    // Unmapped window 50..63 is walked through, then wraps back to 0 like 49 does.
    assign w_ptr_inc = ((r_ptr == LAST_MAPPED) || (r_ptr == LAST_ADDR)) ? '0 : r_ptr + 1'b1;
    assign w_load_we = (r_state == ST_LOAD) && s_valid_i;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_rem_nxt   = r_rem;
        busy_o      = (r_state != ST_IDLE);
        done_o      = (r_state == ST_DONE);
        s_ready_o   = (r_state == ST_LOAD);
        m_valid_o   = (r_state == ST_UNLOAD);
        unique case (r_state)
            ST_IDLE: begin
                if (start_load_i || start_unload_i) begin
                    w_ptr_nxt = base_i;
                    w_rem_nxt = count_i;
                    if (count_i == '0) begin
                        w_state_nxt = ST_DONE;
                    end else if (start_load_i) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_UNLOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_valid_i) begin
                    w_ptr_nxt = w_ptr_inc;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == 6'd1) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_UNLOAD: begin
                if (m_ready_i) begin
                    w_ptr_nxt = w_ptr_inc;
                    w_rem_nxt = r_rem - 1'b1;
                    if (r_rem == 6'd1) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Later assignments override earlier ones: core < stream load < accelerator.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_regs_nxt[i] = r_regs[i];
            if (we_i && (waddr_i == ADDR_WIDTH'(i))) begin
                w_regs_nxt[i] = wdata_i;
            end
            if (w_load_we && (r_ptr == ADDR_WIDTH'(i))) begin
                w_regs_nxt[i] = s_data_i;
            end
        end
        for (int unsigned i = 0; i < NUM_PQ; i++) begin
            if (we_pq_i[i]) begin
                w_regs_nxt[i] = wdata_pq_i[i];
            end
        end
        for (int unsigned i = 0; i < NUM_GP; i++) begin
            if (we_pq_gp_i[i]) begin
                w_regs_nxt[NUM_PQ + i] = wdata_pq_gp_i[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_regs <= w_regs_nxt;
        end
    end

`ifdef PQ_RF_BYPASS_EN
    assign w_core_src = w_regs_nxt;
`else
    assign w_core_src = r_regs;
`endif

    always_comb begin
        rdata_a_o     = '0;
        rdata_b_o     = '0;
        w_unload_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (raddr_a_i == ADDR_WIDTH'(i)) begin
                rdata_a_o = w_core_src[i];
            end
            if (raddr_b_i == ADDR_WIDTH'(i)) begin
                rdata_b_o = w_core_src[i];
            end
            if (r_ptr == ADDR_WIDTH'(i)) begin
                w_unload_word = r_regs[i];
            end
        end
        m_data_o = (r_state == ST_UNLOAD) ? w_unload_word : '0;
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_PQ; i++) begin
            rdata_pq_o[i] = r_regs[i];
        end
        for (int unsigned i = 0; i < NUM_GP; i++) begin
            rdata_pq_gp_o[i] = r_regs[NUM_PQ + i];
        end
    end

endmodule

// File: tb/tb_pq_register_file.sv
// Scoreboard bench for pq_register_file; expectations for same-cycle core reads
// follow PQ_RF_BYPASS_EN when the bench is compiled with that macro.
module tb_pq_register_file;

    logic        clk;
    logic        rst_n;
    logic [31:0] wdata_pq_i    [0:31];
    logic [31:0] we_pq_i;
    logic [31:0] wdata_pq_gp_i [0:17];
    logic [17:0] we_pq_gp_i;
    logic [31:0] rdata_pq_o    [0:31];
    logic [31:0] rdata_pq_gp_o [0:17];
    logic [5:0]  raddr_a_i, raddr_b_i, waddr_i, base_i, count_i;
    logic [31:0] rdata_a_o, rdata_b_o, wdata_i, s_data_i, m_data_o;
    logic        we_i, start_load_i, start_unload_i, busy_o, done_o;
    logic        s_valid_i, s_ready_o, m_valid_o, m_ready_i;

    int          n_cmp;
    int          n_err;
    int          done_count;
    logic [31:0] shadow [0:63];
    logic [31:0] exp_q  [$];
    logic [5:0]  addr_q [$];

    pq_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .wdata_pq_i(wdata_pq_i), .we_pq_i(we_pq_i),
        .wdata_pq_gp_i(wdata_pq_gp_i), .we_pq_gp_i(we_pq_gp_i),
        .rdata_pq_o(rdata_pq_o), .rdata_pq_gp_o(rdata_pq_gp_o),
        .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i),
        .rdata_a_o(rdata_a_o), .rdata_b_o(rdata_b_o),
        .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
        .start_load_i(start_load_i), .start_unload_i(start_unload_i),
        .base_i(base_i), .count_i(count_i), .busy_o(busy_o), .done_o(done_o),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done_o === 1'b1) done_count++;

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1);
    end

    function automatic logic [5:0] ptr_next(input logic [5:0] p);
        return ((p == 6'd49) || (p == 6'd63)) ? 6'd0 : p + 6'd1;
    endfunction

    task automatic core_write(input logic [5:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(negedge clk);
        we_i = 1'b0;
        if (a < 6'd50) shadow[a] = d;
    endtask

    task automatic test_reset;
        logic [5:0] addrs [4];
        addrs = '{6'd0, 6'd31, 6'd49, 6'd63};
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        foreach (addrs[k]) begin
            raddr_a_i = addrs[k];
            #1;
            n_cmp++;
            if (rdata_a_o !== 32'h0) begin
                n_err++;
                $display("FAIL reset_read[%0d]: got %h expected 00000000", addrs[k], rdata_a_o);
            end
        end
        n_cmp++;
        if ({busy_o, done_o, s_ready_o, m_valid_o} !== 4'b0000 || m_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy/done/rdy/vld=%b m_data=%h expected 0000/0",
                     {busy_o, done_o, s_ready_o, m_valid_o}, m_data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_priority;
        we_pq_i[5] = 1'b1; wdata_pq_i[5] = 32'hAAAA_0000;
        we_pq_gp_i[3] = 1'b1; wdata_pq_gp_i[3] = 32'h0000_3333;
        we_i = 1'b1; waddr_i = 6'd5; wdata_i = 32'h1234_5678;
        @(negedge clk);
        we_pq_i = '0; we_pq_gp_i = '0; we_i = 1'b0;
        shadow[5] = 32'hAAAA_0000; shadow[35] = 32'h0000_3333;
        raddr_a_i = 6'd5; raddr_b_i = 6'd35;
        #1;
        n_cmp++;
        if (rdata_pq_o[5] !== 32'hAAAA_0000 || rdata_a_o !== 32'hAAAA_0000) begin
            n_err++;
            $display("FAIL acc_over_core: got arr=%h core=%h expected aaaa0000", rdata_pq_o[5], rdata_a_o);
        end
        n_cmp++;
        if (rdata_pq_gp_o[3] !== 32'h0000_3333 || rdata_b_o !== 32'h0000_3333) begin
            n_err++;
            $display("FAIL gp_write: got arr=%h core=%h expected 00003333", rdata_pq_gp_o[3], rdata_b_o);
        end
        core_write(6'd55, 32'hFFFF_FFFF);
        raddr_a_i = 6'd55; raddr_b_i = 6'd23;
        #1;
        n_cmp++;
        if (rdata_a_o !== 32'h0 || rdata_b_o !== 32'h0) begin
            n_err++;
            $display("FAIL unmapped_write: got r55=%h r23=%h expected 0/0", rdata_a_o, rdata_b_o);
        end
        @(negedge clk);
    endtask

    task automatic test_count_zero;
        int d0;
        d0 = done_count;
        start_load_i = 1'b1; base_i = 6'd0; count_i = 6'd0;
        @(negedge clk);
        start_load_i = 1'b0;
        #1;
        n_cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b1 || s_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL count_zero_done: got done=%b busy=%b rdy=%b expected 1 1 0", done_o, busy_o, s_ready_o);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy_o !== 1'b0 || done_count - d0 != 1) begin
            n_err++;
            $display("FAIL count_zero_idle: got busy=%b pulses=%0d expected 0 1", busy_o, done_count - d0);
        end
        @(negedge clk);
    endtask

    task automatic test_load;
        int         sent;
        int         d0;
        bit         saw;
        logic [5:0] mp;
        sent = 0; saw = 1'b0; mp = 6'd48;
        d0 = done_count;
        #1;
        n_cmp++;
        if (s_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ready: got %b expected 0", s_ready_o);
        end
        @(negedge clk);
        start_load_i = 1'b1; base_i = 6'd48; count_i = 6'd4;
        @(negedge clk);
        start_load_i = 1'b0;
        for (int c = 0; c < 40 && !saw; c++) begin
            s_valid_i = (sent < 4) && (c % 3 != 1);
            s_data_i  = 32'(sent + 1);
            we_i = (c == 0); waddr_i = 6'd48; wdata_i = 32'hBAD0_0BAD;
            #1;
            if (done_o === 1'b1) begin
                saw = 1'b1;
            end else if (s_valid_i && s_ready_o) begin
                addr_q.push_back(mp);
                exp_q.push_back(s_data_i);
                shadow[mp] = s_data_i;
                mp = ptr_next(mp);
                sent++;
            end
            @(negedge clk);
        end
        s_valid_i = 1'b0; we_i = 1'b0;
        #1;
        n_cmp++;
        if (!saw || sent != 4 || done_count - d0 != 1) begin
            n_err++;
            $display("FAIL load_done: got saw=%0d words=%0d pulses=%0d expected 1 4 1", saw, sent, done_count - d0);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL load_busy_after: got busy=%b done=%b expected 0 0", busy_o, done_o);
        end
        while (addr_q.size() > 0) begin
            raddr_a_i = addr_q.pop_front();
            #1;
            n_cmp++;
            if (rdata_a_o !== exp_q[0]) begin
                n_err++;
                $display("FAIL load_word[%0d]: got %h expected %h", raddr_a_i, rdata_a_o, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (rdata_pq_gp_o[16] !== 32'd1 || rdata_pq_gp_o[17] !== 32'd2 ||
            rdata_pq_o[0] !== 32'd3 || rdata_pq_o[1] !== 32'd4) begin
            n_err++;
            $display("FAIL load_map: got gp16=%h gp17=%h pq0=%h pq1=%h expected 1 2 3 4",
                     rdata_pq_gp_o[16], rdata_pq_gp_o[17], rdata_pq_o[0], rdata_pq_o[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_unload(input logic [5:0] base, input logic [5:0] cnt);
        int         k;
        int         stall;
        int         d0;
        bit         saw;
        logic [5:0] mp;
        k = 0; stall = 0; saw = 1'b0; mp = base;
        d0 = done_count;
        exp_q.delete();
        for (int i = 0; i < int'(cnt); i++) begin
            exp_q.push_back(shadow[mp]);
            mp = ptr_next(mp);
        end
        start_unload_i = 1'b1; base_i = base; count_i = cnt;
        @(negedge clk);
        start_unload_i = 1'b0;
        for (int c = 0; c < 60 && !saw; c++) begin
            start_load_i = (c == 1); base_i = 6'd10; count_i = 6'd5;
            if (m_valid_o === 1'b1 && k == 1 && stall < 2) begin
                m_ready_i = 1'b0;
                stall++;
            end else begin
                m_ready_i = 1'b1;
            end
            #1;
            if (done_o === 1'b1) begin
                saw = 1'b1;
            end else if (m_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unload_extra[%0d]: got %h expected no word", base, m_data_o);
                end else begin
                    if (m_data_o !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL unload_word[%0d.%0d]: got %h expected %h", base, k, m_data_o, exp_q[0]);
                    end
                    if (m_ready_i) begin
                        void'(exp_q.pop_front());
                        k++;
                    end
                end
            end
            @(negedge clk);
        end
        m_ready_i = 1'b0; start_load_i = 1'b0;
        #1;
        n_cmp++;
        if (!saw || k != int'(cnt) || stall != 2 || done_count - d0 != 1) begin
            n_err++;
            $display("FAIL unload_done[%0d]: got saw=%0d words=%0d stalls=%0d pulses=%0d expected 1 %0d 2 1",
                     base, saw, k, stall, done_count - d0, cnt);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || m_valid_o !== 1'b0 || s_ready_o !== 1'b0 || m_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL unload_idle[%0d]: got busy=%b vld=%b rdy=%b data=%h expected 0 0 0 0",
                     base, busy_o, m_valid_o, s_ready_o, m_data_o);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int d0;
        start_load_i = 1'b1; base_i = 6'd10; count_i = 6'd5;
        @(negedge clk);
        start_load_i = 1'b0;
        d0 = done_count;
        for (int i = 0; i < 2; i++) begin
            s_valid_i = 1'b1; s_data_i = 32'h5000_0000 + 32'(i);
            @(negedge clk);
        end
        s_valid_i = 1'b0;
        #1;
        n_cmp++;
        if (rdata_pq_o[10] !== 32'h5000_0000 || busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: got pq10=%h busy=%b expected 50000000 1", rdata_pq_o[10], busy_o);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 50; i++) begin
            n_cmp++;
            if ((i < 32 ? rdata_pq_o[i] : rdata_pq_gp_o[i - 32]) !== 32'h0) begin
                n_err++;
                $display("FAIL abort_clear[%0d]: got nonzero expected 00000000", i);
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || s_ready_o !== 1'b0 || done_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_outputs: got busy=%b rdy=%b done=%b expected 0 0 0", busy_o, s_ready_o, done_o);
        end
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (done_count != d0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: got pulses=%0d busy=%b expected 0 0", done_count - d0, busy_o);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        core_write(6'd7, 32'h0101_0101);
`ifdef PQ_RF_BYPASS_EN
        exp_a = 32'hDEAD_BEEF;
        exp_b = 32'hCAFE_F00D;
`else
        exp_a = 32'h0101_0101;
        exp_b = 32'hDEAD_BEEF;
`endif
        we_i = 1'b1; waddr_i = 6'd7; wdata_i = 32'hDEAD_BEEF; raddr_a_i = 6'd7;
        #1;
        n_cmp++;
        if (rdata_a_o !== exp_a) begin
            n_err++;
            $display("FAIL same_cycle_read: got %h expected %h", rdata_a_o, exp_a);
        end
        @(negedge clk);
        we_i = 1'b0;
        #1;
        n_cmp++;
        if (rdata_a_o !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL post_write_read: got %h expected deadbeef", rdata_a_o);
        end
        we_pq_i[7] = 1'b1; wdata_pq_i[7] = 32'hCAFE_F00D;
        we_i = 1'b1; waddr_i = 6'd7; wdata_i = 32'h0BAD_F00D; raddr_b_i = 6'd7;
        #1;
        n_cmp++;
        if (rdata_b_o !== exp_b) begin
            n_err++;
            $display("FAIL fwd_priority: got %h expected %h", rdata_b_o, exp_b);
        end
        @(negedge clk);
        we_pq_i = '0; we_i = 1'b0;
        #1;
        n_cmp++;
        if (rdata_pq_o[7] !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL acc_wins_7: got %h expected cafef00d", rdata_pq_o[7]);
        end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; done_count = 0;
        rst_n = 1'b1;
        we_pq_i = '0; we_pq_gp_i = '0;
        for (int i = 0; i < 32; i++) wdata_pq_i[i] = '0;
        for (int i = 0; i < 18; i++) wdata_pq_gp_i[i] = '0;
        for (int i = 0; i < 64; i++) shadow[i] = '0;
        raddr_a_i = '0; raddr_b_i = '0; waddr_i = '0; wdata_i = '0; we_i = 1'b0;
        start_load_i = 1'b0; start_unload_i = 1'b0; base_i = '0; count_i = '0;
        s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_priority();
        test_count_zero();
        test_load();
        core_write(6'd0, 32'h1111_0000);
        core_write(6'd1, 32'h2222_0001);
        core_write(6'd2, 32'h3333_0002);
        core_write(6'd49, 32'h4949_4949);
        test_unload(6'd0, 6'd3);
        test_unload(6'd62, 6'd3);
        test_unload(6'd49, 6'd3);
        test_abort();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
